// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - op encodings and default latencies for the multiply/divide unit
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic md_is_mult(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// rtl/md_unit_calc.sv - combinational 64-bit mult/div result, falls back to current hi/lo
module md_calc
    import md_unit_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_dz;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sdiv_b;
    logic [31:0] w_udiv_b;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_sprod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign w_uprod = {32'd0, rs_val} * {32'd0, rt_val};

    // Divisor is forced to 1 on zero so no X reaches the dividers; the result is discarded anyway.
    assign w_dz     = (rt_val == 32'd0);
    assign w_abs_a  = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    assign w_abs_b  = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    assign w_sdiv_b = w_dz ? 32'd1 : w_abs_b;
    assign w_udiv_b = w_dz ? 32'd1 : rt_val;

    // Magnitude division handles 0x80000000 / -1 naturally: quotient wraps back to 0x80000000.
    assign w_sq_mag = w_abs_a / w_sdiv_b;
    assign w_sr_mag = w_abs_a % w_sdiv_b;
    assign w_sq     = (rs_val[31] ^ rt_val[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = rs_val[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq     = rs_val / w_udiv_b;
    assign w_ur     = rs_val % w_udiv_b;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (md_op)
            MD_MULT:  {res_hi, res_lo} = w_sprod;
            MD_MULTU: {res_hi, res_lo} = w_uprod;
            MD_DIV: begin
                if (!w_dz) begin
                    res_hi = w_sr;
                    res_lo = w_sq;
                end
            end
            MD_DIVU: begin
                if (!w_dz) begin
                    res_hi = w_ur;
                    res_lo = w_uq;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit owning HI/LO with fixed-latency busy window
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_ph;
    logic [31:0]      r_pl;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;

    md_calc u_calc (
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi     (r_hi),
        .lo     (r_lo),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo)
    );

    // Any request arriving while the counter runs is dropped; the stall unit normally prevents it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_ph  <= '0;
            r_pl  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_hi <= r_ph;
                r_lo <= r_pl;
            end
        end else begin
            if (md_is_mult(md_op) || md_is_div(md_op)) begin
                r_ph  <= w_res_hi;
                r_pl  <= w_res_lo;
                r_cnt <= md_is_mult(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (md_op == MD_MTHI) begin
                r_hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
                r_lo <= rs_val;
            end
        end
    end

    assign busy = (r_cnt != '0);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
module tb_md_unit;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] sb_q[$];
    int          cyc_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    md_unit dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a32,
                                          input logic [31:0] b32, input logic [31:0] h,
                                          input logic [31:0] l);
        longint a, b, q, r;
        case (op)
            OP_MULT:  begin a = $signed(a32); b = $signed(b32); return a * b; end
            OP_MULTU: begin a = {32'd0, a32}; b = {32'd0, b32}; return a * b; end
            OP_DIV: begin
                if (b32 == 0) return {h, l};
                a = $signed(a32); b = $signed(b32);
                q = a / b; r = a % b;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b32 == 0) return {h, l};
                a = {32'd0, a32}; b = {32'd0, b32};
                q = a / b; r = a % b;
                return {r[31:0], q[31:0]};
            end
            default: return {h, l};
        endcase
    endfunction

    // Caller is at a negedge; the op is launched on the next posedge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input bit interfere);
        logic [63:0] e;
        int bcnt;
        sb_q.push_back(model(op, a, b, m_hi, m_lo));
        cyc_q.push_back(exp_cyc);
        md_op = op; rs_val = a; rt_val = b;
        @(negedge clk);
        md_op = OP_NONE;
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 200) begin
            chk("hold_while_busy", {hi, lo}, {m_hi, m_lo});
            if (interfere && bcnt == 0) begin
                md_op = OP_MTHI; rs_val = 32'hDEAD;
            end else if (interfere && bcnt == 1) begin
                md_op = OP_DIV; rs_val = 32'd9; rt_val = 32'd3;
            end else begin
                md_op = OP_NONE;
            end
            bcnt++;
            @(negedge clk);
        end
        md_op = OP_NONE;
        e = sb_q.pop_front();
        chk("busy_cycles", 64'(bcnt), 64'(cyc_q.pop_front()));
        chk("hi", {32'd0, hi}, {32'd0, e[63:32]});
        chk("lo", {32'd0, lo}, {32'd0, e[31:0]});
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        md_op = op; rs_val = v;
        @(negedge clk);
        md_op = OP_NONE;
        if (op == OP_MTHI) m_hi = v; else m_lo = v;
        chk("mt_busy", {63'd0, busy}, 64'd0);
        chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        reset = 1'b1; md_op = OP_NONE; rs_val = '0; rt_val = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        chk("idle_none", {hi, lo}, 64'd0);

        run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, N_MULT, 1'b0);
        chk("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, N_MULT, 1'b0);
        chk("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, N_DIV, 1'b0);
        chk("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        mt(OP_MTHI, 32'h11);
        mt(OP_MTLO, 32'h22);
        run_op(OP_DIVU, 32'd7, 32'd0, N_DIV, 1'b0);
        chk("divzero_const", {hi, lo}, 64'h00000011_00000022);

        run_op(OP_MULT, 32'd2, 32'd3, N_MULT, 1'b1);
        chk("ignored_const", {hi, lo}, 64'h00000000_00000006);
        mt(OP_MTLO, 32'hBEEF);

        md_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        md_op = OP_NONE;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_hilo", {hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        chk("no_late_commit", {hi, lo}, 64'd0);
        chk("no_late_busy", {63'd0, busy}, 64'd0);

        run_op(OP_MULTU, 32'd3, 32'd4, N_MULT, 1'b0);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, N_DIV, 1'b0);
        chk("div_ovf_const", {hi, lo}, 64'h00000000_80000000);

        run_op(OP_MULT, 32'h12345678, 32'hFEDCBA98, N_MULT, 1'b0);
        run_op(OP_MULT, 32'h80000000, 32'h80000000, N_MULT, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(1, 4));
            run_op(op, $urandom, (i == 3) ? 32'd0 : $urandom, (op <= OP_MULTU) ? N_MULT : N_DIV, 1'b0);
        end

        md_op = 4'd9; rs_val = 32'hCAFE; rt_val = 32'd1;
        @(negedge clk);
        md_op = OP_NONE;
        chk("undef_op_busy", {63'd0, busy}, 64'd0);
        chk("undef_op_hilo", {hi, lo}, {m_hi, m_lo});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the P6 five-stage MIPS pipeline.
- Executes mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes.
- Owns the HI and LO registers.
- Drives `busy` to the hazard/stall unit, which holds mult/div/mf*/mt* instructions in ID while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy duration for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  operation from EX: `MD_NONE=0, `MD_MULT=1, `MD_MULTU=2, `MD_DIV=3, `MD_DIVU=4, `MD_MTHI=5, `MD_MTLO=6; 7-15 are treated as NONE.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mt* source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset: the clock and reset are fixed as one clock `clk`, with `reset` synchronous and active-high. At any edge where reset=1: hi=0, lo=0, busy=0, counter=0, and any in-flight operation is discarded. Reset overrides md_op.
- State: a cycle counter `cnt`, wide enough for max(MULT_CYCLES, DIV_CYCLES). `busy = (cnt != 0)`, registered-derived with no combinational path from md_op. IDLE ⇔ cnt==0.
- Start: at edge T, if busy==0 and md_op is MULT/MULTU/DIV/DIVU:
  - compute the 64-bit result from rs_val/rt_val into pending registers ph/pl;
  - load cnt with MULT_CYCLES or DIV_CYCLES.
- In flight: busy is high in cycles T+1..T+N; cnt decrements each edge.
- Commit: on the edge where cnt goes 1→0, hi<=ph and lo<=pl. The new values are visible in the same cycle busy first reads 0.
  - Example, N=5: start edge 0, busy high cycles 1-5, hi/lo new from cycle 6.
- mthi/mtlo: if busy==0, hi<=rs_val (MTHI) or lo<=rs_val (MTLO) at the edge; busy does not assert.
- Requests while busy: any md_op while busy==1 is ignored, with no effect on cnt, ph/pl, hi or lo. The stall unit prevents this case; the block must still tolerate it.
- Reads: hi/lo are plain register outputs. mfhi/mflo read them only when busy==0, which the stall unit guarantees. There is no bypass of pending results.
- Arithmetic:
  - mult: signed 32x32→64 product, {hi,lo} = $signed(rs)*$signed(rt).
  - multu: unsigned product.
  - div: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (div or divu with rt_val==0): busy still asserts for DIV_CYCLES, but hi/lo are left unchanged at commit; ph/pl are loaded with the current hi/lo. No X may propagate.
- Back-to-back: a new start is accepted at the edge where busy is 0 again, i.e. the first cycle after commit. md_op==NONE at every idle edge leaves all state unchanged.

Decomposition:
- const.v: `MD_*` op encodings, plus default cycle counts as `MD_MULT_CYCLES`/`MD_DIV_CYCLES` for the parameter defaults.
- Sub-module `md_calc`: purely combinational (md_op, rs_val, rt_val, hi, lo) → (res_hi, res_lo). Holds the signed/unsigned mult/div and divide-by-zero rules.
- md_unit itself holds the counter, pending registers, HI/LO and the start/commit control.

Test Plan:
- Signed mult: MULT rs=0xFFFFFFFD (-3), rt=5 → busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged while busy.
- Unsigned mult: MULTU rs=0xFFFFFFFF, rt=2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- Signed div: DIV rs=0xFFFFFFF9 (-7), rt=2 → busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Follow-up: DIVU rs=7, rt=0 with prior hi=0x11, lo=0x22 → busy 10 cycles, then hi=0x11, lo=0x22.
- Ignored requests while busy: start MULT rs=2, rt=3, then drive MTHI rs=0xDEAD and DIV rs=9, rt=3 during busy → after 5 cycles hi=0, lo=6; the MTHI and DIV had no effect.
  - Then MTLO rs=0xBEEF while idle → lo=0xBEEF the next cycle, busy stays 0.
- Reset mid-operation: DIV started, reset=1 asserted at busy cycle 4 → next cycle busy=0, hi=0, lo=0, and no late commit.
  - Then MULTU rs=3, rt=4 → hi=0, lo=12 after 5 cycles.
- Corner cases: DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Back-to-back MULTs: the second is started in the first cycle busy reads 0 → busy low for exactly that one cycle.
